// File: rtl/pic_init_sequencer.sv
// Bus-master sequencer that writes ICW1..ICW4 and OCW1 into the 8259 control unit.
// ICW3 and ICW4 are skipped according to the SNGL and IC4 bits of the latched ICW1.
module pic_init_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic       START,
    input  logic [7:0] ICW1,
    input  logic [7:0] ICW2,
    input  logic [7:0] ICW3,
    input  logic [7:0] ICW4,
    input  logic [7:0] OCW1,
    output logic       WR_ENABLE,
    output logic       A0,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StGap,
        StFinish
    } state_e;

    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d, idx_next;
    logic [7:0]       icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q;
    logic [7:0]       icw1_d, icw2_d, icw3_d, icw4_d, ocw1_d;
    logic             last_word;
    logic [7:0]       word;
    logic             wr_d, a0_d, oe_d, busy_d, done_d, err_d;
    logic [7:0]       data_d;

    // Slot index: 0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4, 4=OCW1, 5=end of list.
    always_comb begin
        idx_next = idx_q + 3'd1;
        if (idx_next == 3'd2 && icw1_q[1]) idx_next = 3'd3;
        if (idx_next == 3'd3 && !icw1_q[0]) idx_next = 3'd4;
        last_word = (idx_next == 3'd5);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        icw1_d  = icw1_q;
        icw2_d  = icw2_q;
        icw3_d  = icw3_q;
        icw4_d  = icw4_q;
        ocw1_d  = ocw1_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START && ICW1[4]) begin
                    icw1_d  = ICW1;
                    icw2_d  = ICW2;
                    icw3_d  = ICW3;
                    icw4_d  = ICW4;
                    ocw1_d  = OCW1;
                    idx_d   = 3'd0;
                    state_d = StSetup;
                end else if (START) begin
                    err_d = 1'b1;
                end
            end
            StSetup: begin
                cnt_d   = STROBE_LOAD;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == '0) state_d = StHold;
                else cnt_d = cnt_q - 1'b1;
            end
            StHold: begin
                if (GAP_CYCLES != 0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = StGap;
                end else if (last_word) begin
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_next;
                    state_d = StSetup;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (last_word) begin
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_next;
                    state_d = StSetup;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        case (idx_d)
            3'd0:    word = icw1_d;
            3'd1:    word = icw2_d;
            3'd2:    word = icw3_d;
            3'd3:    word = icw4_d;
            default: word = ocw1_d;
        endcase
        wr_d   = (state_d == StStrobe);
        oe_d   = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
        busy_d = oe_d || (state_d == StGap);
        done_d = (state_d == StFinish);
        a0_d   = oe_d && (idx_d != 3'd0);
        data_d = oe_d ? word : 8'h00;
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            icw1_q    <= 8'h00;
            icw2_q    <= 8'h00;
            icw3_q    <= 8'h00;
            icw4_q    <= 8'h00;
            ocw1_q    <= 8'h00;
            WR_ENABLE <= 1'b0;
            A0        <= 1'b0;
            DATA_OUT  <= 8'h00;
            DATA_OE   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            icw1_q    <= icw1_d;
            icw2_q    <= icw2_d;
            icw3_q    <= icw3_d;
            icw4_q    <= icw4_d;
            ocw1_q    <= ocw1_d;
            WR_ENABLE <= wr_d;
            A0        <= a0_d;
            DATA_OUT  <= data_d;
            DATA_OE   <= oe_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
            ERR       <= err_d;
        end
    end

endmodule
